// File: rtl/mips_store_buffer.sv
// Posted-write store buffer between MEM stage and word-addressed data memory.
// Optional in-place store coalescing is enabled by defining MIPS_SB_COALESCE_EN.
module mips_store_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ADDR_W-1:0]        cpu_address,
  input  logic [DATA_W-1:0]        cpu_write_data,
  input  logic                     cpu_mem_write,
  input  logic                     cpu_mem_read,
  output logic [DATA_W-1:0]        cpu_read_data,
  output logic                     stall,
  output logic                     sb_empty,
  output logic [$clog2(DEPTH):0]   sb_count,
  output logic [ADDR_W-1:0]        address,
  output logic [DATA_W-1:0]        write_data,
  output logic                     mem_write,
  output logic                     mem_read,
  input  logic [DATA_W-1:0]        read_data
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } sb_entry_t;

  sb_entry_t        entry_q [DEPTH];
  sb_entry_t        entry_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             full_c;
  logic             drain_c;
  logic             load_c;
  logic             enq_c;
  logic             coalesce_c;
  logic             match_c;
  logic [PTR_W-1:0] match_idx_c;
  logic [DATA_W-1:0] match_data_c;

  assign full_c  = (count_q == CNT_W'(DEPTH));
  assign drain_c = (count_q != '0) && !cpu_mem_read;
  assign load_c  = cpu_mem_read && !cpu_mem_write;

  // Scan oldest to youngest so the last hit is the youngest matching entry.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx          = '0;
    match_c      = 1'b0;
    match_idx_c  = '0;
    match_data_c = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      idx = head_q + PTR_W'(k);
      if ((CNT_W'(k) < count_q) && (entry_q[idx].addr == cpu_address)) begin
        match_c      = 1'b1;
        match_idx_c  = idx;
        match_data_c = entry_q[idx].data;
      end
    end
  end

`ifdef MIPS_SB_COALESCE_EN
  // A head entry leaving this cycle cannot absorb the store; it is queued anew.
  assign coalesce_c = cpu_mem_write && match_c && !((match_idx_c == head_q) && drain_c);
`else
  assign coalesce_c = 1'b0;
`endif

  assign enq_c = cpu_mem_write && !full_c && !coalesce_c;
  assign stall = cpu_mem_write && full_c && !coalesce_c;

  // Next-state for pointers, count and storage.
  always_comb begin
    entry_d = entry_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (enq_c) begin
      entry_d[tail_q] = '{addr: cpu_address, data: cpu_write_data};
      tail_d          = tail_q + PTR_W'(1);
    end
    if (coalesce_c) begin
      entry_d[match_idx_c].data = cpu_write_data;
    end
    if (drain_c) begin
      head_d = head_q + PTR_W'(1);
    end
    case ({enq_c, drain_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int i = 0; i < int'(DEPTH); i++) begin
        entry_q[i] <= entry_d[i];
      end
    end
  end

  // Memory-side and CPU-side result muxing; idle drives zeros.
  always_comb begin
    mem_write     = 1'b0;
    mem_read      = 1'b0;
    address       = '0;
    write_data    = '0;
    cpu_read_data = '0;
    if (load_c) begin
      mem_read      = 1'b1;
      address       = cpu_address;
      cpu_read_data = match_c ? match_data_c : read_data;
    end else if (drain_c) begin
      mem_write  = 1'b1;
      address    = entry_q[head_q].addr;
      write_data = entry_q[head_q].data;
    end
  end

  assign sb_count = count_q;
  assign sb_empty = (count_q == '0);

endmodule

// File: tb/tb_mips_store_buffer.sv
// Randomized and directed bench for mips_store_buffer against a queue-based model.
module tb_mips_store_buffer;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [ADDR_W-1:0]      cpu_address;
  logic [DATA_W-1:0]      cpu_write_data;
  logic                   cpu_mem_write;
  logic                   cpu_mem_read;
  logic [DATA_W-1:0]      cpu_read_data;
  logic                   stall;
  logic                   sb_empty;
  logic [$clog2(DEPTH):0] sb_count;
  logic [ADDR_W-1:0]      address;
  logic [DATA_W-1:0]      write_data;
  logic                   mem_write;
  logic                   mem_read;
  logic [DATA_W-1:0]      read_data;

  mips_store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_address(cpu_address), .cpu_write_data(cpu_write_data),
    .cpu_mem_write(cpu_mem_write), .cpu_mem_read(cpu_mem_read),
    .cpu_read_data(cpu_read_data), .stall(stall),
    .sb_empty(sb_empty), .sb_count(sb_count),
    .address(address), .write_data(write_data),
    .mem_write(mem_write), .mem_read(mem_read),
    .read_data(read_data)
  );

  always #5 clk = ~clk;

  // Small memory; only the low four address bits are decoded.
  logic [31:0] mem [16];
  assign read_data = mem[address[3:0]];

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;
  ent_t q[$];

  int errors = 0;
  int checks = 0;

  logic        obs_stall, obs_mw, obs_mr, obs_empty;
  logic [31:0] obs_addr, obs_wd, obs_rd, obs_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus: predict, compare at negedge, then advance the model.
  task automatic step(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
    int          cnt;
    int          hj;
    bit          drain, load, hit;
    logic [31:0] e_addr, e_wd, e_rd;
    cpu_mem_write  = w;
    cpu_mem_read   = r;
    cpu_address    = a;
    cpu_write_data = d;
    cnt   = q.size();
    drain = (cnt > 0) && !r;
    load  = r && !w;
    hj    = -1;
    for (int j = 0; j < cnt; j++) if (q[j].a == a) hj = j;
    hit = 1'b0;
`ifdef MIPS_SB_COALESCE_EN
    hit = w && (hj >= 0) && !((hj == 0) && drain);
`endif
    e_rd   = load ? ((hj >= 0) ? q[hj].d : mem[a[3:0]]) : 32'h0;
    e_addr = load ? a : (drain ? q[0].a : 32'h0);
    e_wd   = drain ? q[0].d : 32'h0;
    @(negedge clk);
    obs_stall = stall;
    obs_mw    = mem_write;
    obs_mr    = mem_read;
    obs_empty = sb_empty;
    obs_addr  = address;
    obs_wd    = write_data;
    obs_rd    = cpu_read_data;
    obs_cnt   = 32'(sb_count);
    chk("stall", 32'(stall), 32'(w && (cnt == DEPTH) && !hit));
    chk("mem_write", 32'(mem_write), 32'(drain));
    chk("mem_read", 32'(mem_read), 32'(load));
    chk("address", address, e_addr);
    chk("write_data", write_data, e_wd);
    chk("cpu_read_data", cpu_read_data, e_rd);
    chk("sb_count", obs_cnt, 32'(cnt));
    chk("sb_empty", 32'(sb_empty), 32'(cnt == 0));
    @(posedge clk);
    if (hit) q[hj].d = d;
    if (drain) begin
      mem[q[0].a[3:0]] = q[0].d;
      void'(q.pop_front());
    end
    if (w && !hit && (cnt < DEPTH)) q.push_back({a, d});
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h100 + 32'(i);
    mem[9] = 32'h77;
    rst_n = 1'b0;
    cpu_mem_write = 1'b0; cpu_mem_read = 1'b0;
    cpu_address = '0; cpu_write_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Idle after reset.
    idle(1);
    chk("reset_empty", 32'(obs_empty), 32'd1);
    chk("reset_count", obs_cnt, 32'd0);
    chk("reset_addr", obs_addr, 32'd0);

    // Single store then drain.
    step(1'b1, 1'b0, 32'd5, 32'h11);
    idle(1);
    chk("t1_count1", obs_cnt, 32'd1);
    chk("t1_mw", 32'(obs_mw), 32'd1);
    chk("t1_addr", obs_addr, 32'd5);
    chk("t1_wd", obs_wd, 32'h11);
    idle(1);
    chk("t1_count0", obs_cnt, 32'd0);
    chk("t1_empty", 32'(obs_empty), 32'd1);

    // Fill while loads hold the drain, then overflow.
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b1, 32'(i), 32'h20 + 32'(i));
    step(1'b1, 1'b1, 32'd5, 32'h25);
    chk("t2_count", obs_cnt, 32'd4);
    chk("t2_stall", 32'(obs_stall), 32'd1);
    chk("t2_mw", 32'(obs_mw), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      idle(1);
      chk("t2_order", obs_addr, 32'(i));
    end
    idle(1);

    // Forwarding from buffer vs. memory.
    step(1'b1, 1'b0, 32'd8, 32'hAA);
    step(1'b1, 1'b0, 32'd8, 32'hBB);
    step(1'b0, 1'b1, 32'd8, 32'h0);
    chk("t3_fwd", obs_rd, 32'hBB);
    chk("t3_mw", 32'(obs_mw), 32'd0);
    step(1'b0, 1'b1, 32'd9, 32'h0);
    chk("t3_mem", obs_rd, 32'h77);
    idle(3);

    // Reset pulse mid-drain discards buffered stores.
    step(1'b1, 1'b1, 32'd12, 32'hDEAD);
    step(1'b1, 1'b1, 32'd13, 32'hBEEF);
    cpu_mem_write = 1'b0; cpu_mem_read = 1'b0;
    cpu_address = '0; cpu_write_data = '0;
    @(negedge clk);
    chk("t4_draining", 32'(mem_write), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t4_count", 32'(sb_count), 32'd0);
    chk("t4_mw", 32'(mem_write), 32'd0);
    q.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b0, 1'b1, 32'd12, 32'h0);
    chk("t4_load", obs_rd, 32'h10C);

    // Full buffer with drain and store in the same cycle.
    step(1'b1, 1'b1, 32'd0, 32'h30);
    step(1'b1, 1'b1, 32'd6, 32'h31);
    step(1'b1, 1'b1, 32'd7, 32'h32);
    step(1'b1, 1'b1, 32'd10, 32'h33);
    step(1'b1, 1'b0, 32'd11, 32'h55);
    chk("t5_stall", 32'(obs_stall), 32'd1);
    chk("t5_count4", obs_cnt, 32'd4);
    step(1'b1, 1'b0, 32'd11, 32'h55);
    chk("t5_accept", 32'(obs_stall), 32'd0);
    chk("t5_count3", obs_cnt, 32'd3);
    idle(1);
    chk("t5_count_hold", obs_cnt, 32'd3);
    idle(4);

    // Duplicate address stores.
    step(1'b1, 1'b1, 32'd3, 32'd1);
    step(1'b1, 1'b1, 32'd3, 32'd2);
    step(1'b0, 1'b1, 32'd3, 32'd0);
    chk("t6_fwd", obs_rd, 32'd2);
`ifdef MIPS_SB_COALESCE_EN
    chk("t6_count", obs_cnt, 32'd1);
    idle(1);
    chk("t6_wd", obs_wd, 32'd2);
`else
    chk("t6_count", obs_cnt, 32'd2);
    idle(1);
    chk("t6_wd1", obs_wd, 32'd1);
    idle(1);
    chk("t6_wd2", obs_wd, 32'd2);
`endif
    idle(2);

    // Randomized traffic over a narrow address range to exercise hits.
    for (int n = 0; n < 3000; n++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
           32'($urandom_range(0, 7)), $urandom);
    end
    idle(DEPTH + 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
